// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - command/operand and HI/LO result bundle for the EX-stage mul/div unit
interface hilo_muldiv_if;
  logic [3:0]  mdOP;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  modport master (output mdOP, output A, output B, input HI, input LO, input busy);
  modport slave  (input mdOP, input A, input B, output HI, output LO, output busy);
endinterface

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - fixed-latency HI/LO multiply/divide unit; MULTDIV_MADD_EN enables madd (mdOP 9)
module hilo_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  hilo_muldiv_if.slave   md
);
  localparam int CW = 16;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, r_hi, r_lo;
  logic          busy_q;

  logic          is_madd, is_mul, is_div, is_start;
  logic signed [63:0] prod_s;
  logic [63:0]   prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]   quot_u, rem_u;
  logic [63:0]   res;

  always_comb begin
    is_madd = 1'b0;
`ifdef MULTDIV_MADD_EN
    is_madd = (md.mdOP == 4'd9);
`endif
    is_mul   = (md.mdOP == 4'd1) || (md.mdOP == 4'd2) || is_madd;
    is_div   = (md.mdOP == 4'd3) || (md.mdOP == 4'd4);
    is_start = is_mul || is_div;
  end

  assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
  assign prod_u = {32'd0, md.A} * {32'd0, md.B};

  // Divider is only evaluated with a nonzero divisor; B==0 keeps HI/LO below.
  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (md.B != 32'd0) begin
      quot_s = $signed(md.A) / $signed(md.B);
      rem_s  = $signed(md.A) % $signed(md.B);
      quot_u = md.A / md.B;
      rem_u  = md.A % md.B;
    end
  end

  always_comb begin
    res = {hi_q, lo_q};
    case (md.mdOP)
      4'd1:    res = prod_s;
      4'd2:    res = prod_u;
      4'd3:    if (md.B != 32'd0) res = {rem_s, quot_s};
      4'd4:    if (md.B != 32'd0) res = {rem_u, quot_u};
      default: if (is_madd) res = {hi_q, lo_q} + prod_s;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_start) state_d = RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy rises one edge after acceptance so it covers exactly latency-1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      busy_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (is_start) begin
        r_hi  <= res[63:32];
        r_lo  <= res[31:0];
        cnt_q <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (md.mdOP == 4'd5) begin
        hi_q <= md.A;
      end else if (md.mdOP == 4'd6) begin
        lo_q <= md.A;
      end
    end else begin
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= (cnt_q != CW'(1));
      if (cnt_q == CW'(1)) begin
        hi_q <= r_hi;
        lo_q <= r_lo;
      end
    end
  end

  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
  assign md.busy = busy_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized self-checking bench for hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_if mif();
  hilo_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(mif));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {hi, lo};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return acc;
        q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        if ((sa < 0) != (sb < 0)) q = -q;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return acc;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd9: return acc + sa * sb;
      default: return acc;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.mdOP = op;
    mif.A    = a;
    mif.B    = b;
    @(negedge clk);
    mif.mdOP = 4'd0;
    mif.A    = $urandom;
    mif.B    = $urandom;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, nb;
    logic [63:0] exp;
    lat = (op == 4'd3 || op == 4'd4) ? DC : MC;
    exp = model(op, a, b, m_hi, m_lo);
    nb  = 0;
    issue(op, a, b);
    n_checks++;
    if (mif.busy !== 1'b0) $display("FAIL start_busy op=%0d: got %b want 0", op, mif.busy);
    else n_pass++;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (mif.busy === 1'b1) nb++;
      if (k == lat - 1) begin
        n_checks++;
        if ({mif.HI, mif.LO} !== {m_hi, m_lo})
          $display("FAIL early_commit op=%0d: got %h want %h", op, {mif.HI, mif.LO}, {m_hi, m_lo});
        else n_pass++;
      end
    end
    n_checks++;
    if (nb !== lat - 1) $display("FAIL busy_cycles op=%0d: got %0d want %0d", op, nb, lat - 1);
    else n_pass++;
    n_checks++;
    if ({mif.HI, mif.LO} !== exp)
      $display("FAIL result op=%0d a=%h b=%h: got %h want %h", op, a, b, {mif.HI, mif.LO}, exp);
    else n_pass++;
    {m_hi, m_lo} = exp;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    issue(op, a, $urandom);
    if (op == 4'd5) m_hi = a;
    if (op == 4'd6) m_lo = a;
    n_checks++;
    if ({mif.HI, mif.LO, mif.busy} !== {m_hi, m_lo, 1'b0})
      $display("FAIL move op=%0d: got %h/%h/%b want %h/%h/0", op, mif.HI, mif.LO, mif.busy, m_hi, m_lo);
    else n_pass++;
  endtask

  task automatic test_reset();
    mif.mdOP = 4'd0;
    mif.A    = '0;
    mif.B    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mif.HI, mif.LO, mif.busy} !== 65'd0)
      $display("FAIL reset_state: got %h/%h/%b want 0/0/0", mif.HI, mif.LO, mif.busy);
    else n_pass++;
  endtask

  task automatic test_mult_sign();
    run_op(4'd1, 32'hFFFFFFFF, 32'd2);
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'hFFFFFFFF_FFFFFFFE) $display("FAIL mult_const: got %h/%h want ffffffff/fffffffe", mif.HI, mif.LO);
    else n_pass++;
    run_op(4'd2, 32'hFFFFFFFF, 32'd2);
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'h00000001_FFFFFFFE) $display("FAIL multu_const: got %h/%h want 00000001/fffffffe", mif.HI, mif.LO);
    else n_pass++;
  endtask

  task automatic test_div();
    run_op(4'd3, 32'hFFFFFFF9, 32'd2);
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_const: got %h/%h want ffffffff/fffffffd", mif.HI, mif.LO);
    else n_pass++;
    run_op(4'd4, 32'd7, 32'd2);
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'h00000001_00000003) $display("FAIL divu_const: got %h/%h want 1/3", mif.HI, mif.LO);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    mt(4'd6, 32'h1234);
    mt(4'd5, 32'h5678);
    run_op(4'd4, 32'd7, 32'd0);
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'h00005678_00001234) $display("FAIL divzero_const: got %h/%h want 5678/1234", mif.HI, mif.LO);
    else n_pass++;
  endtask

  task automatic test_run_ignore();
    issue(4'd1, 32'd3, 32'd5);
    issue(4'd5, 32'hDEAD, 32'd0);
    issue(4'd1, 32'd7, 32'd7);
    repeat (MC - 2) @(negedge clk);
    n_checks++;
    if ({mif.HI, mif.LO, mif.busy} !== {32'd0, 32'd15, 1'b0})
      $display("FAIL run_ignore_commit: got %h/%h/%b want 0/f/0", mif.HI, mif.LO, mif.busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mif.busy !== 1'b0) $display("FAIL run_ignore_nostart: got %b want 0", mif.busy);
    else n_pass++;
    m_hi = 32'd0;
    m_lo = 32'd15;
    mt(4'd5, 32'hDEAD);
  endtask

  task automatic test_reset_mid();
    int nb;
    mt(4'd5, 32'hAAAA);
    mt(4'd6, 32'hBBBB);
    issue(4'd1, 32'hFFFF, 32'hFFFF);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({mif.HI, mif.LO, mif.busy} !== 65'd0)
      $display("FAIL reset_mid_clear: got %h/%h/%b want 0/0/0", mif.HI, mif.LO, mif.busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    nb = 0;
    repeat (12) begin
      @(negedge clk);
      if (mif.busy !== 1'b0) nb++;
    end
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'd0 || nb != 0)
      $display("FAIL reset_mid_nocommit: got %h/%h busy_cycles=%0d want 0/0/0", mif.HI, mif.LO, nb);
    else n_pass++;
  endtask

  task automatic test_madd();
    mt(4'd5, 32'd0);
    mt(4'd6, 32'hFFFFFFFF);
`ifdef MULTDIV_MADD_EN
    run_op(4'd9, 32'd1, 32'd1);
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'h00000001_00000000) $display("FAIL madd_const: got %h/%h want 1/0", mif.HI, mif.LO);
    else n_pass++;
`else
    issue(4'd9, 32'd1, 32'd1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mif.busy !== 1'b0) $display("FAIL madd_off_busy k=%0d: got %b want 0", k, mif.busy);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({mif.HI, mif.LO} !== 64'h00000000_FFFFFFFF) $display("FAIL madd_off_hilo: got %h/%h want 0/ffffffff", mif.HI, mif.LO);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (op == 4'd1 || op == 4'd2) b = $urandom;
      if (op == 4'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      if (op <= 4'd4) run_op(op, a, b);
      else mt(op, a);
    end
  endtask

  task automatic test_back_to_back();
    run_op(4'd1, 32'h80000000, 32'h80000000);
    run_op(4'd3, 32'h00000064, 32'hFFFFFFF9);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
  endtask

  initial begin
    test_reset();
    test_mult_sign();
    test_div();
    test_div_zero();
    test_run_ignore();
    test_reset_mid();
    test_madd();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multiply/divide responder for the EX stage: accepts a one-cycle `mdOP` command with two 32-bit operands, runs a fixed-latency multiply or divide, and commits the result into the architectural HI/LO registers. It sits beside the ALU in EX. EX stalls the pipeline while `busy` is high or while a new start command is present, and reads HI/LO combinationally for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles from accepting mult/multu to HI/LO commit.
- `DIV_CYCLES`, default 10: cycles from accepting div/divu to HI/LO commit.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `mdOP`  in  4: command. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd (macro-gated).
- `A`  in  32: rs operand (dividend / multiplicand / mthi-mtlo source).
- `B`  in  32: rt operand (divisor / multiplier).
- `HI`  out  32: architectural HI register.
- `LO`  out  32: architectural LO register.
- `busy`  out  1: an accepted multiply/divide is in flight.

## Operation
- States: IDLE, RUN. Reset value: state IDLE, `HI`=0, `LO`=0, `busy`=0, counter=0.
- **Start in IDLE.** A start is `mdOP` in {1,2,3,4,9}. On a start edge:
  - compute the 64-bit result into shadow registers `rHI`/`rLO`;
  - load the counter with `MULT_CYCLES` (1,2,9) or `DIV_CYCLES` (3,4);
  - enter RUN.
- **Result arithmetic:**
  - mult: signed 32x32 product to 64 bits, {rHI,rLO}.
  - multu: unsigned 32x32 product to 64 bits, {rHI,rLO}.
  - div: rLO = signed quotient truncated toward zero; rHI = remainder with the dividend's sign.
  - divu: unsigned quotient in rLO, unsigned remainder in rHI.
  - div/divu with B==0: shadow registers load the current HI/LO, so the commit leaves HI/LO unchanged. Busy timing is still the full `DIV_CYCLES`.
- **RUN:**
  - the counter decrements each edge;
  - on the edge where the counter goes 1 to 0, HI<=rHI, LO<=rLO, and the state returns to IDLE;
  - any `mdOP` during RUN (start, mthi, mtlo) is ignored.
- **mthi/mtlo in IDLE:** HI<=A or LO<=A on the edge. No busy, no state change.
- **mdOP 0, 7, 8:** no state change. HI/LO are always visible on the outputs.
- **Reset mid-operation:** asynchronously returns to IDLE and clears HI, LO, counter and the shadow registers. The in-flight result is discarded.

## Timing
- Start accepted at edge T0. `busy`=1 for edges T0+1 through T0+N-1, where N is the latency. The commit edge is T0+N; `busy` falls and HI/LO update at that same edge.
- `busy` is a registered output. It is 0 in the start cycle itself, and EX ORs in the start term.
- A new start is accepted at the commit edge's following cycle at the earliest, i.e. back-to-back with no idle gap.
- mthi/mtlo take effect at the same edge they are presented, with 0 added latency.
- An mfhi/mflo issued after `busy` falls sees the committed value.

## Configuration
- `MULTDIV_MADD_EN` defined: mdOP 9 (madd) is a start with `MULT_CYCLES` latency. {rHI,rLO} = {HI,LO} + signed(A*B), 64-bit wrap-around with no overflow flag.
- Undefined: mdOP 9 is treated as a no-op exactly like 0. It does not assert `busy`.

## Test plan
- **Signed vs unsigned multiply:**
  - mult, A=0xFFFFFFFF, B=2: HI=0xFFFFFFFF, LO=0xFFFFFFFE at T0+5; `busy` high for exactly 4 sampled cycles.
  - multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- **Signed divide rounding:** div, A=-7 (0xFFFFFFF9), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF at T0+10. divu, A=7, B=2: LO=3, HI=1.
- **Divide by zero:** mtlo A=0x1234, mthi A=0x5678, then divu A=7, B=0: `busy` for 9 cycles; HI=0x5678, LO=0x1234 afterward.
- **Commands during RUN:** mthi A=0xDEAD and a second mult issued during RUN have no effect. The first result commits unchanged, and a later mthi in IDLE writes HI=0xDEAD immediately.
- **Reset mid-operation:** drop `reset` asynchronously at T0+3 of a mult. `busy`, HI and LO are 0 immediately, and no commit occurs after release.
- **madd (with `MULTDIV_MADD_EN`):** HI=0, LO=0xFFFFFFFF, then madd A=1, B=1: HI=1, LO=0 at T0+5. Without the macro: `busy` stays 0 and HI/LO are unchanged.
